// File: rtl/snake_body_if.sv
// snake_body_if: move-request handshake, head/length status and the body segment stream.
interface snake_body_if;
   logic       step;
   logic       step_ready;
   logic [1:0] dir;
   logic       grow;
   logic [4:0] head_x;
   logic [3:0] head_y;
   logic [5:0] length;
   logic [4:0] snake_x;
   logic [3:0] snake_y;
   logic       snake_first;
   logic       snake_last;
   logic       snake_valid;
   logic       failure;
   logic       success;

   modport master (
      output step, dir, grow,
      input  step_ready, head_x, head_y, length,
      input  snake_x, snake_y, snake_first, snake_last, snake_valid,
      input  failure, success
   );

   modport slave (
      input  step, dir, grow,
      output step_ready, head_x, head_y, length,
      output snake_x, snake_y, snake_first, snake_last, snake_valid,
      output failure, success
   );
endinterface

// File: rtl/snake_body_stream.sv
// snake_body_stream: snake body ring buffer, move FSM with collision check, and a continuous
// newest-to-oldest body segment stream. Define SNAKE_WRAP_EN to wrap at the playfield edges.
module snake_body_stream #(
   parameter int unsigned GAME_WIDTH  = 18,
   parameter int unsigned GAME_HEIGHT = 13,
   parameter int unsigned MAX_LEN     = 32,
   parameter int unsigned INIT_LEN    = 3
) (
   input logic         clk,
   input logic         rst,
   snake_body_if.slave bus
);
   localparam int unsigned XW  = 5;
   localparam int unsigned YW  = 4;
   localparam int unsigned PW  = $clog2(MAX_LEN);
   localparam int unsigned LW  = PW + 1;
   localparam int unsigned HX0 = GAME_WIDTH / 2;
   localparam int unsigned HY0 = GAME_HEIGHT / 2;

   typedef enum logic [1:0] {IDLE, CALC, CHECK, COMMIT} state_t;

   state_t        state;
   logic [XW-1:0] seg_x [MAX_LEN];
   logic [YW-1:0] seg_y [MAX_LEN];
   logic [PW-1:0] head_ptr;
   logic [LW-1:0] len;
   logic [XW-1:0] hx;
   logic [YW-1:0] hy;
   logic [1:0]    last_dir;
   logic [1:0]    mv_dir;
   logic          mv_grow;
   logic [XW-1:0] new_x;
   logic [YW-1:0] new_y;
   logic          coll;
   logic          armed;
   logic          rdy;
   logic          failed;
   logic          succeeded;

   logic [PW-1:0] rd_ptr;
   logic [LW-1:0] rd_cnt;
   logic [LW-1:0] pass_len;
   logic          in_gap;
   logic [XW-1:0] sx;
   logic [YW-1:0] sy;
   logic          sfirst;
   logic          slast;
   logic          svalid;

   logic [XW-1:0] nx_c;
   logic [YW-1:0] ny_c;
   logic          wall_c;
   logic [1:0]    dir_c;

   // Direction actually taken: a direct reversal keeps the previous heading
   assign dir_c = ((bus.dir ^ 2'd2) == last_dir) ? last_dir : bus.dir;

   // Candidate head one cell along the latched direction, with wall/wrap handling
   always_comb begin
      nx_c   = hx;
      ny_c   = hy;
      wall_c = 1'b0;
      case (mv_dir)
         2'd0:    nx_c = hx + XW'(1);
         2'd1:    ny_c = hy + YW'(1);
         2'd2:    nx_c = hx - XW'(1);
         default: ny_c = hy - YW'(1);
      endcase
`ifdef SNAKE_WRAP_EN
      if (nx_c == '0)                         nx_c = XW'(GAME_WIDTH);
      else if (nx_c == XW'(GAME_WIDTH + 1))   nx_c = XW'(1);
      if (ny_c == '0)                         ny_c = YW'(GAME_HEIGHT);
      else if (ny_c == YW'(GAME_HEIGHT + 1))  ny_c = YW'(1);
`else
      wall_c = (nx_c == '0) || (nx_c == XW'(GAME_WIDTH + 1)) ||
               (ny_c == '0) || (ny_c == YW'(GAME_HEIGHT + 1));
`endif
   end

   // Move FSM and body buffer
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         head_ptr  <= PW'(INIT_LEN - 1);
         len       <= LW'(INIT_LEN);
         hx        <= XW'(HX0);
         hy        <= YW'(HY0);
         last_dir  <= 2'd0;
         mv_dir    <= 2'd0;
         mv_grow   <= 1'b0;
         new_x     <= '0;
         new_y     <= '0;
         coll      <= 1'b0;
         armed     <= 1'b0;
         rdy       <= 1'b1;
         failed    <= 1'b0;
         succeeded <= 1'b0;
         for (int unsigned i = 0; i < MAX_LEN; i++) begin
            seg_x[i] <= (i < INIT_LEN) ? XW'(HX0 + i + 1 - INIT_LEN) : '0;
            seg_y[i] <= (i < INIT_LEN) ? YW'(HY0) : '0;
         end
      end else begin
         case (state)
            IDLE: begin
               if (bus.step && rdy) begin
                  mv_dir   <= dir_c;
                  last_dir <= dir_c;
                  mv_grow  <= bus.grow;
                  rdy      <= 1'b0;
                  state    <= CALC;
               end
            end
            CALC: begin
               new_x <= nx_c;
               new_y <= ny_c;
               coll  <= wall_c;
               armed <= 1'b0;
               state <= (len == LW'(1)) ? COMMIT : CHECK;
            end
            CHECK: begin
               // Scan exactly one full pass; the tail is free to step onto unless growing
               if (svalid && (sfirst || armed)) begin
                  armed <= 1'b1;
                  if (sx == new_x && sy == new_y && !(slast && !mv_grow))
                     coll <= 1'b1;
                  if (slast)
                     state <= COMMIT;
               end
            end
            COMMIT: begin
               if (coll) begin
                  failed <= 1'b1;
               end else begin
                  head_ptr <= head_ptr + PW'(1);
                  seg_x[head_ptr + PW'(1)] <= new_x;
                  seg_y[head_ptr + PW'(1)] <= new_y;
                  hx <= new_x;
                  hy <= new_y;
                  if (mv_grow) begin
                     len <= len + LW'(1);
                     if (len == LW'(MAX_LEN - 1))
                        succeeded <= 1'b1;
                  end
                  rdy <= !(mv_grow && len == LW'(MAX_LEN - 1));
               end
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Segment stream: pointers latched at pass start, so a commit only shows on the next pass
   always_ff @(posedge clk) begin
      if (rst) begin
         rd_ptr   <= PW'(INIT_LEN - 2);
         rd_cnt   <= '0;
         pass_len <= LW'(INIT_LEN - 1);
         in_gap   <= 1'b0;
         sx       <= '0;
         sy       <= '0;
         sfirst   <= 1'b0;
         slast    <= 1'b0;
         svalid   <= 1'b0;
      end else if (in_gap || pass_len == '0) begin
         svalid   <= 1'b0;
         sfirst   <= 1'b0;
         slast    <= 1'b0;
         rd_ptr   <= head_ptr - PW'(1);
         rd_cnt   <= '0;
         pass_len <= len - LW'(1);
         in_gap   <= 1'b0;
      end else begin
         svalid <= 1'b1;
         sfirst <= (rd_cnt == '0);
         slast  <= (rd_cnt == pass_len - LW'(1));
         sx     <= seg_x[rd_ptr];
         sy     <= seg_y[rd_ptr];
         rd_ptr <= rd_ptr - PW'(1);
         rd_cnt <= rd_cnt + LW'(1);
         in_gap <= (rd_cnt == pass_len - LW'(1));
      end
   end

   assign bus.step_ready  = rdy;
   assign bus.head_x      = hx;
   assign bus.head_y      = hy;
   assign bus.length      = len;
   assign bus.snake_x     = sx;
   assign bus.snake_y     = sy;
   assign bus.snake_first = sfirst;
   assign bus.snake_last  = slast;
   assign bus.snake_valid = svalid;
   assign bus.failure     = failed;
   assign bus.success     = succeeded;

endmodule

// File: tb/tb_snake_body_stream.sv
// tb_snake_body_stream: directed scenario tasks for snake_body_stream (honours SNAKE_WRAP_EN).
module tb_snake_body_stream;
   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   snake_body_if bus ();
   snake_body_stream dut (.clk(clk), .rst(rst), .bus(bus.slave));

   int checks = 0;
   int errors = 0;

   logic [4:0] cap_x [32];
   logic [3:0] cap_y [32];
   int         cap_n;
   bit         cap_ok;
   int         exp_x [32];
   int         exp_y [32];
   int         exp_n;

   function automatic bit stream_ok();
      if (!cap_ok || cap_n != exp_n) return 1'b0;
      for (int i = 0; i < exp_n; i++)
         if (int'(cap_x[i]) != exp_x[i] || int'(cap_y[i]) != exp_y[i]) return 1'b0;
      return 1'b1;
   endfunction

   // Record one full pass starting at the next snake_first; also expects one gap clk then a restart
   task automatic capture_pass();
      int guard = 0;
      cap_n  = 0;
      cap_ok = 1'b1;
      @(negedge clk);
      while (!(bus.snake_valid && bus.snake_first) && guard < 200) begin
         @(negedge clk);
         guard++;
      end
      if (guard >= 200) begin
         cap_ok = 1'b0;
         return;
      end
      forever begin
         if (!bus.snake_valid || (cap_n > 0 && bus.snake_first)) begin
            cap_ok = 1'b0;
            return;
         end
         cap_x[cap_n] = bus.snake_x;
         cap_y[cap_n] = bus.snake_y;
         cap_n++;
         if (bus.snake_last) break;
         if (cap_n >= 32) begin
            cap_ok = 1'b0;
            return;
         end
         @(negedge clk);
      end
      @(negedge clk);
      if (bus.snake_valid) cap_ok = 1'b0;
      @(negedge clk);
      if (!(bus.snake_valid && bus.snake_first)) cap_ok = 1'b0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      bus.step = 1'b0;
      @(negedge clk);
      rst = 1'b0;
   endtask

   // One move; ok=0 if the step could not be issued or never completed
   task automatic do_step(input logic [1:0] d, input logic g, output bit ok, output int lat);
      int guard = 0;
      ok  = 1'b1;
      lat = 0;
      while (!bus.step_ready && !bus.failure && !bus.success && guard < 300) begin
         @(negedge clk);
         guard++;
      end
      if (!bus.step_ready) begin
         ok = 1'b0;
         return;
      end
      bus.step = 1'b1;
      bus.dir  = d;
      bus.grow = g;
      @(negedge clk);
      bus.step = 1'b0;
      lat = 1;
      while (!(bus.step_ready || bus.failure || bus.success) && lat < 300) begin
         @(negedge clk);
         lat++;
      end
      ok = bus.step_ready || bus.failure || bus.success;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      bus.step = 1'b0;
      @(negedge clk);
      checks++; if (bus.head_x !== 5'd9) begin errors++; $display("FAIL reset_head_x got %0d exp 9", bus.head_x); end
      checks++; if (bus.head_y !== 4'd6) begin errors++; $display("FAIL reset_head_y got %0d exp 6", bus.head_y); end
      checks++; if (bus.length !== 6'd3) begin errors++; $display("FAIL reset_length got %0d exp 3", bus.length); end
      checks++; if (bus.step_ready !== 1'b1) begin errors++; $display("FAIL reset_step_ready got %b exp 1", bus.step_ready); end
      checks++; if (bus.failure !== 1'b0 || bus.success !== 1'b0) begin errors++; $display("FAIL reset_flags got %b%b exp 00", bus.failure, bus.success); end
      checks++; if (bus.snake_valid !== 1'b0) begin errors++; $display("FAIL reset_snake_valid got %b exp 0", bus.snake_valid); end
      rst = 1'b0;
   endtask

   task automatic test_stream();
      exp_n = 2; exp_x[0] = 8; exp_y[0] = 6; exp_x[1] = 7; exp_y[1] = 6;
      for (int p = 0; p < 2; p++) begin
         capture_pass();
         checks++;
         if (!stream_ok()) begin
            errors++;
            $display("FAIL reset_stream pass %0d got ok=%b n=%0d first=(%0d,%0d) exp n=2 (8,6)..(7,6)", p, cap_ok, cap_n, cap_x[0], cap_y[0]);
         end
      end
   endtask

   task automatic test_step_right();
      bit ok; int lat;
      do_step(2'd0, 1'b0, ok, lat);
      checks++; if (!ok) begin errors++; $display("FAIL step_right_done got timeout exp completion"); end
      checks++; if (bus.head_x !== 5'd10 || bus.head_y !== 4'd6) begin errors++; $display("FAIL step_right_head got (%0d,%0d) exp (10,6)", bus.head_x, bus.head_y); end
      checks++; if (bus.length !== 6'd3) begin errors++; $display("FAIL step_right_length got %0d exp 3", bus.length); end
      checks++; if (lat < 5 || lat > 7) begin errors++; $display("FAIL step_right_latency got %0d exp 5..7", lat); end
      capture_pass();
      exp_n = 2; exp_x[0] = 9; exp_y[0] = 6; exp_x[1] = 8; exp_y[1] = 6;
      checks++; if (!stream_ok()) begin errors++; $display("FAIL step_right_stream got n=%0d first=(%0d,%0d) exp n=2 (9,6)", cap_n, cap_x[0], cap_y[0]); end
   endtask

   task automatic test_reverse_ignored();
      bit ok; int lat;
      do_step(2'd2, 1'b0, ok, lat);
      checks++; if (!ok || bus.head_x !== 5'd11 || bus.head_y !== 4'd6) begin errors++; $display("FAIL reverse_head got (%0d,%0d) exp (11,6)", bus.head_x, bus.head_y); end
      checks++; if (bus.failure !== 1'b0) begin errors++; $display("FAIL reverse_failure got %b exp 0", bus.failure); end
   endtask

   task automatic test_wall();
      bit ok; int lat;
      do_reset();
      for (int k = 0; k < 9; k++) do_step(2'd0, 1'b0, ok, lat);
      checks++; if (bus.head_x !== 5'd18 || bus.failure !== 1'b0) begin errors++; $display("FAIL wall_edge got x=%0d fail=%b exp x=18 fail=0", bus.head_x, bus.failure); end
      do_step(2'd0, 1'b0, ok, lat);
`ifdef SNAKE_WRAP_EN
      checks++; if (bus.head_x !== 5'd1 || bus.failure !== 1'b0) begin errors++; $display("FAIL wall_wrap got x=%0d fail=%b exp x=1 fail=0", bus.head_x, bus.failure); end
      checks++; if (bus.step_ready !== 1'b1) begin errors++; $display("FAIL wall_wrap_ready got %b exp 1", bus.step_ready); end
      exp_n = 2; exp_x[0] = 18; exp_y[0] = 6; exp_x[1] = 17; exp_y[1] = 6;
`else
      checks++; if (bus.head_x !== 5'd18 || bus.failure !== 1'b1) begin errors++; $display("FAIL wall_hit got x=%0d fail=%b exp x=18 fail=1", bus.head_x, bus.failure); end
      repeat (2) @(negedge clk);
      checks++; if (bus.step_ready !== 1'b0) begin errors++; $display("FAIL wall_hit_ready got %b exp 0", bus.step_ready); end
      exp_n = 2; exp_x[0] = 17; exp_y[0] = 6; exp_x[1] = 16; exp_y[1] = 6;
`endif
      capture_pass();
      checks++; if (!stream_ok()) begin errors++; $display("FAIL wall_stream got n=%0d first=(%0d,%0d) exp n=2 first=(%0d,%0d)", cap_n, cap_x[0], cap_y[0], exp_x[0], exp_y[0]); end
   endtask

   task automatic test_self_collision();
      bit ok; int lat;
      do_reset();
      do_step(2'd0, 1'b1, ok, lat);
      do_step(2'd0, 1'b1, ok, lat);
      checks++; if (bus.length !== 6'd5 || bus.head_x !== 5'd11) begin errors++; $display("FAIL self_setup got len=%0d x=%0d exp len=5 x=11", bus.length, bus.head_x); end
      do_step(2'd1, 1'b0, ok, lat);
      do_step(2'd2, 1'b0, ok, lat);
      do_step(2'd3, 1'b0, ok, lat);
      checks++; if (bus.failure !== 1'b1) begin errors++; $display("FAIL self_failure got %b exp 1", bus.failure); end
      checks++; if (bus.head_x !== 5'd10 || bus.head_y !== 4'd7 || bus.length !== 6'd5) begin errors++; $display("FAIL self_head_kept got (%0d,%0d) len=%0d exp (10,7) len=5", bus.head_x, bus.head_y, bus.length); end
      bus.step = 1'b1; bus.dir = 2'd1;
      repeat (4) @(negedge clk);
      bus.step = 1'b0;
      checks++; if (bus.step_ready !== 1'b0 || bus.head_y !== 4'd7) begin errors++; $display("FAIL self_sticky got ready=%b y=%0d exp ready=0 y=7", bus.step_ready, bus.head_y); end
      capture_pass();
      exp_n = 4;
      exp_x[0] = 11; exp_y[0] = 7; exp_x[1] = 11; exp_y[1] = 6;
      exp_x[2] = 10; exp_y[2] = 6; exp_x[3] = 9;  exp_y[3] = 6;
      checks++; if (!stream_ok()) begin errors++; $display("FAIL self_stream got n=%0d first=(%0d,%0d) exp n=4 first=(11,7)", cap_n, cap_x[0], cap_y[0]); end
   endtask

   task automatic test_tail_vacate();
      bit ok; int lat;
      do_reset();
      do_step(2'd0, 1'b1, ok, lat);
      do_step(2'd1, 1'b0, ok, lat);
      do_step(2'd2, 1'b0, ok, lat);
      do_step(2'd3, 1'b0, ok, lat);
      checks++; if (bus.failure !== 1'b0 || bus.head_x !== 5'd9 || bus.head_y !== 4'd6) begin errors++; $display("FAIL tail_vacate got fail=%b (%0d,%0d) exp fail=0 (9,6)", bus.failure, bus.head_x, bus.head_y); end
      capture_pass();
      exp_n = 3;
      exp_x[0] = 9; exp_y[0] = 7; exp_x[1] = 10; exp_y[1] = 7; exp_x[2] = 10; exp_y[2] = 6;
      checks++; if (!stream_ok()) begin errors++; $display("FAIL tail_vacate_stream got n=%0d first=(%0d,%0d) exp n=3 first=(9,7)", cap_n, cap_x[0], cap_y[0]); end
      do_reset();
      do_step(2'd0, 1'b1, ok, lat);
      do_step(2'd1, 1'b0, ok, lat);
      do_step(2'd2, 1'b0, ok, lat);
      do_step(2'd3, 1'b1, ok, lat);
      checks++; if (bus.failure !== 1'b1 || bus.head_x !== 5'd9 || bus.head_y !== 4'd7) begin errors++; $display("FAIL tail_kept_on_grow got fail=%b (%0d,%0d) exp fail=1 (9,7)", bus.failure, bus.head_x, bus.head_y); end
   endtask

   task automatic test_reset_mid_check();
      bit ok; int lat;
      do_reset();
      bus.step = 1'b1; bus.dir = 2'd0; bus.grow = 1'b0;
      @(negedge clk);
      bus.step = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      checks++; if (bus.head_x !== 5'd9 || bus.head_y !== 4'd6 || bus.length !== 6'd3) begin errors++; $display("FAIL midreset_head got (%0d,%0d) len=%0d exp (9,6) len=3", bus.head_x, bus.head_y, bus.length); end
      capture_pass();
      exp_n = 2; exp_x[0] = 8; exp_y[0] = 6; exp_x[1] = 7; exp_y[1] = 6;
      checks++; if (!stream_ok()) begin errors++; $display("FAIL midreset_stream got n=%0d first=(%0d,%0d) exp n=2 (8,6)", cap_n, cap_x[0], cap_y[0]); end
      do_step(2'd1, 1'b0, ok, lat);
      capture_pass();
      exp_n = 2; exp_x[0] = 9; exp_y[0] = 6; exp_x[1] = 8; exp_y[1] = 6;
      checks++; if (bus.head_y !== 4'd7 || !stream_ok()) begin errors++; $display("FAIL midreset_next_step got y=%0d first=(%0d,%0d) exp y=7 (9,6)", bus.head_y, cap_x[0], cap_y[0]); end
   endtask

   task automatic test_wraparound();
      bit ok; int lat;
      do_reset();
      for (int k = 0; k < 40; k++) do_step(2'(k % 4), 1'b0, ok, lat);
      checks++; if (bus.failure !== 1'b0 || bus.head_x !== 5'd9 || bus.head_y !== 4'd6) begin errors++; $display("FAIL ring_head got fail=%b (%0d,%0d) exp fail=0 (9,6)", bus.failure, bus.head_x, bus.head_y); end
      capture_pass();
      exp_n = 2; exp_x[0] = 9; exp_y[0] = 7; exp_x[1] = 10; exp_y[1] = 7;
      checks++; if (!stream_ok()) begin errors++; $display("FAIL ring_stream got n=%0d first=(%0d,%0d) exp n=2 (9,7)", cap_n, cap_x[0], cap_y[0]); end
   endtask

   task automatic test_grow_success();
      bit ok; int lat;
      logic [1:0] d;
      do_reset();
      do_step(2'd0, 1'b1, ok, lat);
      checks++; if (bus.length !== 6'd4) begin errors++; $display("FAIL grow_length got %0d exp 4", bus.length); end
      capture_pass();
      exp_n = 3;
      exp_x[0] = 9; exp_y[0] = 6; exp_x[1] = 8; exp_y[1] = 6; exp_x[2] = 7; exp_y[2] = 6;
      checks++; if (!stream_ok()) begin errors++; $display("FAIL grow_stream got n=%0d first=(%0d,%0d) exp n=3 (9,6)", cap_n, cap_x[0], cap_y[0]); end
      for (int k = 1; k < 29; k++) begin
         d = (k < 9) ? 2'd0 : (k == 9) ? 2'd1 : (k < 27) ? 2'd2 : (k == 27) ? 2'd1 : 2'd0;
         do_step(d, 1'b1, ok, lat);
      end
      checks++; if (bus.success !== 1'b1 || bus.failure !== 1'b0) begin errors++; $display("FAIL success_flag got s=%b f=%b exp s=1 f=0", bus.success, bus.failure); end
      checks++; if (bus.length !== 6'd32 || bus.head_x !== 5'd2 || bus.head_y !== 4'd8) begin errors++; $display("FAIL success_state got len=%0d (%0d,%0d) exp len=32 (2,8)", bus.length, bus.head_x, bus.head_y); end
      repeat (2) @(negedge clk);
      checks++; if (bus.step_ready !== 1'b0) begin errors++; $display("FAIL success_ready got %b exp 0", bus.step_ready); end
      capture_pass();
      checks++;
      if (!cap_ok || cap_n != 31 || cap_x[0] !== 5'd1 || cap_y[0] !== 4'd8 || cap_x[30] !== 5'd7 || cap_y[30] !== 4'd6) begin
         errors++;
         $display("FAIL success_stream got ok=%b n=%0d first=(%0d,%0d) last=(%0d,%0d) exp n=31 (1,8)..(7,6)", cap_ok, cap_n, cap_x[0], cap_y[0], cap_x[30], cap_y[30]);
      end
   endtask

   initial begin
      rst      = 1'b1;
      bus.step = 1'b0;
      bus.dir  = 2'd0;
      bus.grow = 1'b0;
      repeat (2) @(negedge clk);
      test_reset();
      test_stream();
      test_step_right();
      test_reverse_ignored();
      test_wall();
      test_self_collision();
      test_tail_vacate();
      test_reset_mid_check();
      test_wraparound();
      test_grow_success();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout got no finish exp finish");
      $fatal(1);
   end
endmodule
